// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding controller and its MD busy tracker.
package hazard_pkg;

  localparam logic [1:0] FWD_GRF   = 2'b00;
  localparam logic [1:0] FWD_E_PC8 = 2'b01;
  localparam logic [1:0] FWD_M_ALU = 2'b10;
  localparam logic [1:0] FWD_M_PC8 = 2'b11;

  localparam logic [1:0] E_FWD_NONE  = 2'b00;
  localparam logic [1:0] E_FWD_M_ALU = 2'b01;
  localparam logic [1:0] E_FWD_M_PC8 = 2'b10;
  localparam logic [1:0] E_FWD_W     = 2'b11;

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_t;

endpackage

// File: rtl/hazard_ctrl_md_busy_tracker.sv
// Multiply/divide busy tracker: holds md_busy high for the op latency after issue.
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_is_div,
  output logic md_busy
);

  localparam int unsigned MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  md_state_t     state;
  logic [CW-1:0] md_cnt;

  // md_cnt holds the busy cycles still to go, including the current one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= MD_IDLE;
      md_cnt  <= '0;
      md_busy <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (md_start) begin
            md_cnt  <= md_is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
            state   <= MD_BUSY;
            md_busy <= 1'b1;
          end
        end
        MD_BUSY: begin
          if (md_cnt == CW'(1)) begin
            md_cnt  <= '0;
            state   <= MD_IDLE;
            md_busy <= 1'b0;
          end else begin
            md_cnt <= md_cnt - 1'b1;
          end
        end
        default: begin
          state   <= MD_IDLE;
          md_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl_md.sv
// Tuse/Tnew hazard controller: stall, flush and forwarding selects, MD busy stalls,
// and a saturating stall-cycle counter.
module hazard_ctrl_md
  import hazard_pkg::*;
#(
  parameter int unsigned AW       = 5,
  parameter int unsigned TW       = 2,
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [TW-1:0]    rs_tuse,
  input  logic [TW-1:0]    rt_tuse,
  input  logic [TW-1:0]    tnew_e,
  input  logic [TW-1:0]    tnew_m,
  input  logic [TW-1:0]    tnew_w,
  input  logic [AW-1:0]    rs_d,
  input  logic [AW-1:0]    rt_d,
  input  logic [AW-1:0]    a1_e,
  input  logic [AW-1:0]    a2_e,
  input  logic [AW-1:0]    a3_e,
  input  logic [AW-1:0]    a2_m,
  input  logic [AW-1:0]    a3_m,
  input  logic [AW-1:0]    a3_w,
  input  logic             regwrite_e,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  input  logic             jal_m,
  input  logic             md_start_e,
  input  logic             md_is_div_e,
  input  logic             md_use_d,
  output logic             en_pc,
  output logic             en_fd,
  output logic             flush_de,
  output logic [1:0]       rd1_dsel,
  output logic [1:0]       rd2_dsel,
  output logic [1:0]       srca_sel,
  output logic [1:0]       srcb_sel,
  output logic             dm_wd_sel,
  output logic             md_busy,
  output logic             stall_data,
  output logic             stall_md,
  output logic [CNT_W-1:0] stall_cnt
);

  function automatic logic hit(input logic [AW-1:0] x, input logic [AW-1:0] y,
                               input logic we);
    return (x == y) && (x != '0) && we;
  endfunction

  function automatic logic [1:0] d_fwd(input logic e_hit, input logic m_hit,
                                       input logic e_rdy, input logic m_rdy,
                                       input logic jal);
    if (e_hit && e_rdy)      return FWD_E_PC8;
    else if (m_hit && m_rdy) return jal ? FWD_M_PC8 : FWD_M_ALU;
    else                     return FWD_GRF;
  endfunction

  function automatic logic [1:0] e_fwd(input logic m_hit, input logic w_hit,
                                       input logic m_rdy, input logic w_rdy,
                                       input logic jal);
    if (m_hit && !jal && m_rdy) return E_FWD_M_ALU;
    else if (m_hit && jal)      return E_FWD_M_PC8;
    else if (w_hit && w_rdy)    return E_FWD_W;
    else                        return E_FWD_NONE;
  endfunction

  logic rs_e_hit, rs_m_hit, rt_e_hit, rt_m_hit;
  logic a1_m_hit, a1_w_hit, a2_m_hit, a2_w_hit, dm_w_hit;
  logic e_rdy, m_rdy, w_rdy, stall;

  assign rs_e_hit = hit(rs_d, a3_e, regwrite_e);
  assign rs_m_hit = hit(rs_d, a3_m, regwrite_m);
  assign rt_e_hit = hit(rt_d, a3_e, regwrite_e);
  assign rt_m_hit = hit(rt_d, a3_m, regwrite_m);
  assign a1_m_hit = hit(a1_e, a3_m, regwrite_m);
  assign a1_w_hit = hit(a1_e, a3_w, regwrite_w);
  assign a2_m_hit = hit(a2_e, a3_m, regwrite_m);
  assign a2_w_hit = hit(a2_e, a3_w, regwrite_w);
  assign dm_w_hit = hit(a2_m, a3_w, regwrite_w);

  assign e_rdy = (tnew_e == '0);
  assign m_rdy = (tnew_m == '0);
  assign w_rdy = (tnew_w == '0);

  assign stall_data = (rs_e_hit && (rs_tuse < tnew_e)) || (rs_m_hit && (rs_tuse < tnew_m))
                   || (rt_e_hit && (rt_tuse < tnew_e)) || (rt_m_hit && (rt_tuse < tnew_m));
  assign stall_md   = md_use_d & (md_start_e | md_busy);
  assign stall      = stall_data | stall_md;

  assign en_pc    = ~stall;
  assign en_fd    = ~stall;
  assign flush_de = stall;

  assign rd1_dsel  = d_fwd(rs_e_hit, rs_m_hit, e_rdy, m_rdy, jal_m);
  assign rd2_dsel  = d_fwd(rt_e_hit, rt_m_hit, e_rdy, m_rdy, jal_m);
  assign srca_sel  = e_fwd(a1_m_hit, a1_w_hit, m_rdy, w_rdy, jal_m);
  assign srcb_sel  = e_fwd(a2_m_hit, a2_w_hit, m_rdy, w_rdy, jal_m);
  assign dm_wd_sel = dm_w_hit && w_rdy;

  md_busy_tracker #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy (
    .clk       (clk),
    .reset     (reset),
    .md_start  (md_start_e),
    .md_is_div (md_is_div_e),
    .md_busy   (md_busy)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_ctrl_md.sv
// Scoreboard bench for hazard_ctrl_md: directed vectors push expectations, a
// negedge monitor pops and compares.
module tb_hazard_ctrl_md;

  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] rs_tuse, rt_tuse, tnew_e, tnew_m, tnew_w;
  logic [4:0] rs_d, rt_d, a1_e, a2_e, a3_e, a2_m, a3_m, a3_w;
  logic regwrite_e, regwrite_m, regwrite_w, jal_m;
  logic md_start_e, md_is_div_e, md_use_d;
  logic en_pc, en_fd, flush_de, dm_wd_sel, md_busy, stall_data, stall_md;
  logic [1:0] rd1_dsel, rd2_dsel, srca_sel, srcb_sel;
  logic [CW-1:0] stall_cnt;

  hazard_ctrl_md #(
    .AW(5), .TW(2), .MULT_CYC(5), .DIV_CYC(10), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .rs_tuse(rs_tuse), .rt_tuse(rt_tuse),
    .tnew_e(tnew_e), .tnew_m(tnew_m), .tnew_w(tnew_w),
    .rs_d(rs_d), .rt_d(rt_d),
    .a1_e(a1_e), .a2_e(a2_e), .a3_e(a3_e),
    .a2_m(a2_m), .a3_m(a3_m), .a3_w(a3_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .jal_m(jal_m), .md_start_e(md_start_e), .md_is_div_e(md_is_div_e),
    .md_use_d(md_use_d),
    .en_pc(en_pc), .en_fd(en_fd), .flush_de(flush_de),
    .rd1_dsel(rd1_dsel), .rd2_dsel(rd2_dsel),
    .srca_sel(srca_sel), .srcb_sel(srcb_sel),
    .dm_wd_sel(dm_wd_sel), .md_busy(md_busy),
    .stall_data(stall_data), .stall_md(stall_md), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         nm;
    logic [14:0]   v;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          q[$];
  int            total = 0;
  int            bad = 0;
  logic [CW-1:0] exp_cnt = '0;

  task automatic quiet();
    rs_tuse = '0; rt_tuse = '0; tnew_e = '0; tnew_m = '0; tnew_w = '0;
    rs_d = '0; rt_d = '0; a1_e = '0; a2_e = '0; a3_e = '0;
    a2_m = '0; a3_m = '0; a3_w = '0;
    regwrite_e = 1'b0; regwrite_m = 1'b0; regwrite_w = 1'b0; jal_m = 1'b0;
    md_start_e = 1'b0; md_is_div_e = 1'b0; md_use_d = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs for the current cycle; stall_cnt expectation follows a
  // saturating count of the stalls expected in earlier cycles.
  task automatic push(input string nm, input logic sd, input logic smd, input logic busy,
                      input logic [1:0] r1, input logic [1:0] r2,
                      input logic [1:0] sa, input logic [1:0] sb, input logic dm);
    exp_t e;
    logic st;
    st    = sd | smd;
    e.nm  = nm;
    e.v   = {~st, ~st, st, r1, r2, sa, sb, dm, busy, sd, smd};
    e.cnt = exp_cnt;
    q.push_back(e);
    if (st && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [14:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {en_pc, en_fd, flush_de, rd1_dsel, rd2_dsel, srca_sel, srcb_sel,
               dm_wd_sel, md_busy, stall_data, stall_md};
        total++;
        if (act !== e.v) begin
          bad++;
          $display("FAIL %s outputs: got %b want %b", e.nm, act, e.v);
        end
        total++;
        if (stall_cnt !== e.cnt) begin
          bad++;
          $display("FAIL %s stall_cnt: got %0d want %0d", e.nm, stall_cnt, e.cnt);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    quiet();
    tick();
    reset = 1'b0;
    push("reset", 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);

    tick(); quiet(); a3_e = 5'd1; regwrite_e = 1; tnew_e = 2'd2; rs_d = 5'd1;
    push("lw_e_stall", 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    tick(); quiet();
    push("cnt_one", 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    tick(); quiet(); a3_e = 5'd1; regwrite_e = 1; tnew_e = 2'd2; rs_d = 5'd0;
    push("rs_zero", 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    tick(); quiet(); regwrite_e = 1; regwrite_m = 1; regwrite_w = 1; tnew_w = 2'd0;
    push("reg0_all", 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    tick(); quiet(); a3_m = 5'd31; regwrite_m = 1; jal_m = 1; rs_d = 5'd31;
    push("jal_jr", 0, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0);
    tick(); quiet(); a3_m = 5'd5; regwrite_m = 1; rt_d = 5'd5;
    push("rt_m_alu", 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0);
    tick(); quiet(); a3_e = 5'd7; regwrite_e = 1; rs_d = 5'd7; rt_d = 5'd7;
    a3_m = 5'd7; regwrite_m = 1;
    push("e_beats_m", 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0);
    tick(); quiet(); a3_m = 5'd3; regwrite_m = 1; tnew_m = 2'd1; rt_d = 5'd3; rt_tuse = 2'd1;
    push("tuse_eq_tnew", 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    tick(); rt_tuse = 2'd0;
    push("tuse_lt_tnew", 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    tick(); quiet(); a3_m = 5'd2; regwrite_m = 1; a3_w = 5'd2; regwrite_w = 1;
    a1_e = 5'd2; a2_m = 5'd2;
    push("m_over_w", 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 1);
    tick(); regwrite_m = 0;
    push("w_only", 0, 0, 0, 2'b00, 2'b00, 2'b11, 2'b00, 1);
    tick(); quiet(); a3_m = 5'd31; regwrite_m = 1; jal_m = 1; a2_e = 5'd31;
    push("e_jal_m", 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b10, 0);
    tick(); quiet(); a3_w = 5'd4; regwrite_w = 1; tnew_w = 2'd1; a2_e = 5'd4; a2_m = 5'd4;
    push("w_not_ready", 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);

    tick(); quiet(); md_start_e = 1; md_is_div_e = 1; md_use_d = 1;
    push("div_issue", 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    for (int i = 0; i < 10; i++) begin
      tick(); md_start_e = 0; md_is_div_e = 0;
      push("div_busy", 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    end
    tick();
    push("div_release", 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    tick(); quiet();
    push("idle_a", 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);

    tick(); quiet(); md_start_e = 1; md_use_d = 1;
    push("mult_issue", 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    for (int i = 0; i < 5; i++) begin
      tick(); md_start_e = 0;
      push("mult_busy", 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    end
    tick();
    push("mult_release", 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    tick(); quiet();
    push("cnt_saturated", 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);

    tick(); quiet(); md_start_e = 1; md_is_div_e = 1; md_use_d = 1;
    push("div2_issue", 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); md_start_e = 0; md_is_div_e = 0;
      push("div2_busy", 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    end
    tick();
    reset = 1'b1;
    exp_cnt = '0;
    push("reset_mid_div", 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    tick();
    reset = 1'b0;
    push("post_reset", 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    tick(); quiet();
    push("final_idle", 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
